instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 194 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// places returned words into the IF/ID register, and absorbs one word in
// a skid buffer when decode is stalled. Redirects flush IF/ID and the skid
// buffer; a response already in flight when a redirect arrives is dropped.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   o_IMemReq        read request (asserted only in REQ)
//   o_IMemAddr       read address (current fetch PC)
//   i_IMemReady      memory accepts the request this cycle
//   i_IMemRvalid     i_IMemRdata valid this cycle
//   i_IMemRdata      returned instruction word
//   i_Stall          decode cannot accept the held instruction
//   i_Redirect       flush and restart fetch at i_RedirectPC
//   i_RedirectPC     redirect target (low two bits ignored)
//   o_Valid          IF/ID holds a real instruction
//   o_Instr          IF/ID instruction word
//   o_OP             opcode field of o_Instr (combinational)
//   o_PC, o_PCPlus4  IF/ID instruction address and address + 4
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_IMemReq,
  output logic [31:0] o_IMemAddr,
  input  logic        i_IMemReady,
  input  logic        i_IMemRvalid,
  input  logic [31:0] i_IMemRdata,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  output logic        o_Valid,
  output logic [31:0] o_Instr,
  output logic [5:0]  o_OP,
  output logic [31:0] o_PC,
  output logic [31:0] o_PCPlus4
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetchState_t;

  fetchState_t       stateQ, stateD;
  logic [XLEN-1:0]   pcQ, pcD;
  logic              dropQ, dropD;
  logic [XLEN-1:0]   skidInstrQ, skidInstrD;
  logic [XLEN-1:0]   skidPcQ, skidPcD;
  logic              reqQ, reqD;
  logic              validQ, validD;
  logic [XLEN-1:0]   instrQ, instrD;
  logic [XLEN-1:0]   pcOutQ, pcOutD;
  logic [XLEN-1:0]   pcPlus4Q, pcPlus4D;

  logic [XLEN-1:0]   pcPlus4;
  logic [XLEN-1:0]   redirectPc;
  logic              rspTaken;
  logic              ifidFree;
  logic              loadMem;
  logic              loadSkid;

  // Shared event decode used by both combinational processes
  assign pcPlus4    = pcQ + XLEN'(4);
  assign redirectPc = i_RedirectPC & ~XLEN'(3);
  assign rspTaken   = (stateQ == WAIT) && i_IMemRvalid && !dropQ && !i_Redirect;
  assign ifidFree   = !validQ || !i_Stall;
  assign loadMem    = rspTaken && ifidFree;
  assign loadSkid   = !i_Redirect && (stateQ == HOLD) && !i_Stall;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stateQ     <= IDLE;
      pcQ        <= RESET_PC;
      dropQ      <= 1'b0;
      skidInstrQ <= '0;
      skidPcQ    <= '0;
      reqQ       <= 1'b0;
      validQ     <= 1'b0;
      instrQ     <= '0;
      pcOutQ     <= '0;
      pcPlus4Q   <= '0;
    end else begin
      stateQ     <= stateD;
      pcQ        <= pcD;
      dropQ      <= dropD;
      skidInstrQ <= skidInstrD;
      skidPcQ    <= skidPcD;
      reqQ       <= reqD;
      validQ     <= validD;
      instrQ     <= instrD;
      pcOutQ     <= pcOutD;
      pcPlus4Q   <= pcPlus4D;
    end
  end

  // Next state, fetch PC, drop flag and skid buffer
  always_comb begin
    stateD     = stateQ;
    pcD        = pcQ;
    dropD      = dropQ;
    skidInstrD = skidInstrQ;
    skidPcD    = skidPcQ;
    if (i_Redirect) begin
      pcD        = redirectPc;
      skidInstrD = '0;
      skidPcD    = '0;
      unique case (stateQ)
        REQ: begin
          // Request accepted in the same cycle: its response must be dropped
          if (i_IMemReady) begin
            stateD = WAIT;
            dropD  = 1'b1;
          end else begin
            stateD = REQ;
          end
        end
        WAIT: begin
          if (i_IMemRvalid) begin
            stateD = REQ;
            dropD  = 1'b0;
          end else begin
            stateD = WAIT;
            dropD  = 1'b1;
          end
        end
        default: stateD = REQ;
      endcase
    end else begin
      unique case (stateQ)
        IDLE: stateD = REQ;
        REQ: begin
          if (i_IMemReady) stateD = WAIT;
        end
        WAIT: begin
          if (i_IMemRvalid) begin
            stateD = REQ;
            if (dropQ) begin
              dropD = 1'b0;
            end else begin
              pcD = pcPlus4;
              if (!ifidFree) begin
                skidInstrD = i_IMemRdata;
                skidPcD    = pcQ;
                stateD     = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!i_Stall) stateD = REQ;
        end
        default: stateD = IDLE;
      endcase
    end
  end

  // Registered outputs: request strobe and IF/ID register
  always_comb begin
    reqD     = (stateD == REQ);
    validD   = validQ;
    instrD   = instrQ;
    pcOutD   = pcOutQ;
    pcPlus4D = pcPlus4Q;
    if (i_Redirect) begin
      validD = 1'b0;
      instrD = '0;
    end else if (loadMem) begin
      validD   = 1'b1;
      instrD   = i_IMemRdata;
      pcOutD   = pcQ;
      pcPlus4D = pcPlus4;
    end else if (loadSkid) begin
      // In HOLD the fetch PC has already advanced past the skid word
      validD   = 1'b1;
      instrD   = skidInstrQ;
      pcOutD   = skidPcQ;
      pcPlus4D = pcQ;
    end else if (validQ && !i_Stall) begin
      validD = 1'b0;
      instrD = '0;
    end
  end

  assign o_IMemReq  = reqQ;
  assign o_IMemAddr = pcQ;
  assign o_Valid    = validQ;
  assign o_Instr    = instrQ;
  assign o_OP       = instrQ[XLEN-1 -: OP_W];
  assign o_PC       = pcOutQ;
  assign o_PCPlus4  = pcPlus4Q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. The reference model tracks the
// fetch stream at transaction level: the next address the fetcher should
// request, the next address decode should see, how many fetched words are
// buffered, and whether the single in-flight response is stale.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_IMemReq;
  logic [31:0] o_IMemAddr;
  logic        i_IMemReady;
  logic        i_IMemRvalid;
  logic [31:0] i_IMemRdata;
  logic        i_Stall;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic        o_Valid;
  logic [31:0] o_Instr;
  logic [5:0]  o_OP;
  logic [31:0] o_PC;
  logic [31:0] o_PCPlus4;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_IMemReq    (o_IMemReq),
    .o_IMemAddr   (o_IMemAddr),
    .i_IMemReady  (i_IMemReady),
    .i_IMemRvalid (i_IMemRvalid),
    .i_IMemRdata  (i_IMemRdata),
    .i_Stall      (i_Stall),
    .i_Redirect   (i_Redirect),
    .i_RedirectPC (i_RedirectPC),
    .o_Valid      (o_Valid),
    .o_Instr      (o_Instr),
    .o_OP         (o_OP),
    .o_PC         (o_PC),
    .o_PCPlus4    (o_PCPlus4)
  );

  always #5 i_clk = ~i_clk;

  int nCmp = 0;
  int nErr = 0;
  int nConsumed = 0;

  // Reference model state
  logic        outst;
  logic        stale;
  logic [31:0] outAddr;
  int          lat;
  int          bufCount;
  logic [31:0] expPc;
  logic [31:0] expFetch;

  // Memory contents as a pure function of address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    outst    = 1'b0;
    stale    = 1'b0;
    outAddr  = 32'h0;
    lat      = 0;
    bufCount = 0;
    expPc    = RESET_PC;
    expFetch = RESET_PC;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the
  // model with the events of the coming edge, then cross that edge.
  task automatic step(input logic rdy, input logic rv, input logic stl,
                      input logic rdr, input logic [31:0] tgt);
    logic acc;
    logic consume;
    logic kept;
    i_IMemReady  = rdy;
    i_IMemRvalid = rv;
    i_Stall      = stl;
    i_Redirect   = rdr;
    i_RedirectPC = tgt;
    i_IMemRdata  = (rv && outst) ? memWord(outAddr) : 32'hDEAD_BEEF;
    #1;
    chk("valid_model", 32'(o_Valid), 32'(bufCount > 0));
    if (o_Valid) begin
      chk("ifid_pc", o_PC, expPc);
      chk("ifid_pc4", o_PCPlus4, expPc + 32'h4);
      chk("ifid_instr", o_Instr, memWord(expPc));
      chk("ifid_op", 32'(o_OP), memWord(expPc) >> 26);
    end else begin
      chk("instr_flushed", o_Instr, 32'h0);
      chk("op_flushed", 32'(o_OP), 32'h0);
    end
    if (o_IMemReq) chk("fetch_addr", o_IMemAddr, expFetch);
    if (outst || bufCount > 1) chk("req_blocked", 32'(o_IMemReq), 32'h0);

    acc     = o_IMemReq && rdy;
    consume = o_Valid && !stl && !rdr;
    kept    = rv && outst && !stale && !rdr;
    if (consume) begin
      expPc = expPc + 32'h4;
      nConsumed++;
    end
    if (acc && !rdr) expFetch = expFetch + 32'h4;
    if (rv && outst) begin
      outst = 1'b0;
      stale = 1'b0;
    end
    if (acc) begin
      outst   = 1'b1;
      stale   = rdr;
      outAddr = o_IMemAddr;
      lat     = int'($urandom_range(1, 4));
    end else if (outst && rdr) begin
      stale = 1'b1;
    end
    if (rdr) begin
      bufCount = 0;
      expPc    = tgt & ~32'h3;
      expFetch = expPc;
    end else begin
      bufCount = bufCount - (consume ? 1 : 0) + (kept ? 1 : 0);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic randomPhase(input int n);
    for (int c = 0; c < n; c++) begin
      logic rv;
      logic rdr;
      logic [31:0] tgt;
      if (outst) begin
        lat--;
        rv = (lat <= 0);
      end else begin
        rv = ($urandom_range(0, 7) == 0);
      end
      rdr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      step($urandom_range(0, 3) != 0, rv, $urandom_range(0, 2) == 0, rdr, tgt);
    end
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_IMemReady  = 1'b0;
    i_IMemRvalid = 1'b0;
    i_IMemRdata  = 32'h0;
    i_Stall      = 1'b0;
    i_Redirect   = 1'b0;
    i_RedirectPC = 32'h0;
    modelReset();

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_req", 32'(o_IMemReq), 32'h0);
    chk("rst_valid", 32'(o_Valid), 32'h0);
    chk("rst_instr", o_Instr, 32'h0);
    chk("rst_op", 32'(o_OP), 32'h0);
    chk("rst_pc", o_PC, 32'h0);
    chk("rst_pc4", o_PCPlus4, 32'h0);
    chk("rst_addr", o_IMemAddr, RESET_PC);
    i_rst_n = 1'b1;

    // First fetch after reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("idle_to_req", 32'(o_IMemReq), 32'h1);
    chk("first_addr", o_IMemAddr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wait_no_req", 32'(o_IMemReq), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_valid", 32'(o_Valid), 32'h1);
    chk("first_op", 32'(o_OP), 32'h23);
    chk("first_pc", o_PC, 32'h0);
    chk("first_pc4", o_PCPlus4, 32'h4);
    chk("second_addr", o_IMemAddr, 32'h4);

    // Stall with IF/ID full: response for 0x8 parks in the skid buffer
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_req", 32'(o_IMemReq), 32'h0);
    chk("hold_instr", o_Instr, memWord(32'h4));
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("hold_req_stalled", 32'(o_IMemReq), 32'h0);
      chk("hold_instr_stalled", o_Instr, memWord(32'h4));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("skid_pc", o_PC, 32'h8);
    chk("skid_instr", o_Instr, memWord(32'h8));
    chk("skid_pc4", o_PCPlus4, 32'hC);
    chk("skid_next_addr", o_IMemAddr, 32'hC);

    // Redirect while waiting: stale response discarded, PC aligned
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0043);
    chk("redir_wait_valid", 32'(o_Valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_wait_discard", 32'(o_Valid), 32'h0);
    chk("redir_wait_addr", o_IMemAddr, 32'h0000_0040);

    // Redirect in the same cycle the request at 0x10 is accepted
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    chk("redir_req_addr", o_IMemAddr, 32'h10);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_accept_discard", 32'(o_Valid), 32'h0);
    chk("redir_accept_addr", o_IMemAddr, 32'h200);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_accept_pc", o_PC, 32'h200);

    // Redirect while stalled with the skid buffer full
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("skid_full_req", 32'(o_IMemReq), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
    chk("flush_valid", 32'(o_Valid), 32'h0);
    chk("flush_instr", o_Instr, 32'h0);
    chk("flush_addr", o_IMemAddr, 32'h300);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_refill_pc", o_PC, 32'h300);

    // PC wrap-around
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", o_PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", o_PCPlus4, 32'h0);
    chk("wrap_addr", o_IMemAddr, 32'h0);

    // Random traffic against the model
    randomPhase(3000);

    // Reset in the middle of an outstanding request
    for (int k = 0; k < 20 && !outst; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_setup", 32'(outst), 32'h1);
    #2;
    i_rst_n      = 1'b0;
    i_IMemReady  = 1'b0;
    i_IMemRvalid = 1'b0;
    i_Redirect   = 1'b0;
    #1;
    chk("midrst_req", 32'(o_IMemReq), 32'h0);
    chk("midrst_valid", 32'(o_Valid), 32'h0);
    chk("midrst_addr", o_IMemAddr, RESET_PC);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    modelReset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("late_rsp_ignored", 32'(o_Valid), 32'h0);
    chk("late_rsp_req", 32'(o_IMemReq), 32'h1);
    chk("late_rsp_addr", o_IMemAddr, RESET_PC);
    randomPhase(300);
    chk("progress", 32'(nConsumed > 100), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
